// File: rtl/tennis_pkg.sv
// Shared constants for the tennis scoring blocks:
// 7-segment digit codes, set-state encoding and set-rule limits.
package tennis_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] THREE = 7'b0110000;
  localparam logic [6:0] FOUR  = 7'b0011001;
  localparam logic [6:0] FIVE  = 7'b0010010;
  localparam logic [6:0] SIX   = 7'b0000010;
  localparam logic [6:0] SEVEN = 7'b1111000;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0010000;

  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [3:0] GAMES_TO_WIN = 4'd6;
  localparam logic [3:0] WIN_MARGIN   = 4'd2;
  localparam logic [3:0] GAMES_MAX    = 4'd7;

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit to active-low 7-segment decoder.
// Values above nine show a blank digit.
module seg7_digit
  import tennis_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = BLANK;
    unique case (val)
      4'd0:    seg = ZERO;
      4'd1:    seg = ONE;
      4'd2:    seg = TWO;
      4'd3:    seg = THREE;
      4'd4:    seg = FOUR;
      4'd5:    seg = FIVE;
      4'd6:    seg = SIX;
      4'd7:    seg = SEVEN;
      4'd8:    seg = EIGHT;
      4'd9:    seg = NINE;
      default: seg = BLANK;
    endcase
  end

endmodule

// File: rtl/games_in_set.sv
// Games-in-set counter: set-win detection, hold of the final score,
// game digits. GAME_BLINK_EN blinks the set winner's digit during hold.
module games_in_set
  import tennis_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic [6:0] p1_games_seg,
  output logic [6:0] p2_games_seg,
  output logic       p1_set,
  output logic       p2_set,
  output logic       set_over
);

  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (BLINK_CYCLES == 0) begin : g_bad_blink
    $error("BLINK_CYCLES must be at least 1");
  end

  logic [0:0]  state;
  logic [31:0] hold_cnt;
  logic [2:0]  p1_cnt;
  logic [2:0]  p2_cnt;
  logic        p1_q;
  logic        p2_q;

  logic        p1_rise;
  logic        p2_rise;
  logic        ev1;
  logic        ev2;
  logic [3:0]  n1;
  logic [3:0]  n2;
  logic        win1;
  logic        win2;
  logic        hold_done;

  // Simultaneous rises cancel each other out
  always_comb begin
    p1_rise = p1_win & ~p1_q;
    p2_rise = p2_win & ~p2_q;
    ev1     = p1_rise & ~p2_rise;
    ev2     = p2_rise & ~p1_rise;
    n1      = {1'b0, p1_cnt} + 4'd1;
    n2      = {1'b0, p2_cnt} + 4'd1;
    win1    = (n1 >= GAMES_TO_WIN &&
               n1 >= {1'b0, p2_cnt} + WIN_MARGIN) ||
              n1 == GAMES_MAX;
    win2    = (n2 >= GAMES_TO_WIN &&
               n2 >= {1'b0, p1_cnt} + WIN_MARGIN) ||
              n2 == GAMES_MAX;
    hold_done = (hold_cnt == HOLD_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= PLAY;
      hold_cnt <= '0;
      p1_cnt   <= '0;
      p2_cnt   <= '0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      p1_set   <= 1'b0;
      p2_set   <= 1'b0;
      set_over <= 1'b0;
    end else begin
      p1_q   <= p1_win;
      p2_q   <= p2_win;
      p1_set <= 1'b0;
      p2_set <= 1'b0;
      unique case (state)
        PLAY: begin
          if (ev1) begin
            p1_cnt <= n1[2:0];
            if (win1) begin
              state    <= HOLD;
              p1_set   <= 1'b1;
              set_over <= 1'b1;
              hold_cnt <= '0;
            end
          end else if (ev2) begin
            p2_cnt <= n2[2:0];
            if (win2) begin
              state    <= HOLD;
              p2_set   <= 1'b1;
              set_over <= 1'b1;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (hold_done) begin
            state    <= PLAY;
            hold_cnt <= '0;
            p1_cnt   <= '0;
            p2_cnt   <= '0;
            set_over <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  logic [6:0] p1_dig;
  logic [6:0] p2_dig;

  seg7_digit u_p1_dig (
    .val ({1'b0, p1_cnt}),
    .seg (p1_dig)
  );

  seg7_digit u_p2_dig (
    .val ({1'b0, p2_cnt}),
    .seg (p2_dig)
  );

`ifdef GAME_BLINK_EN
  logic        winner;
  logic [31:0] blink_cnt;
  logic        blink_vis;

  // winner: 0 = player 1, 1 = player 2
  always_ff @(posedge clk) begin
    if (!rst) begin
      winner    <= 1'b0;
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (state == PLAY) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
      if (ev1 && win1) begin
        winner <= 1'b0;
      end else if (ev2 && win2) begin
        winner <= 1'b1;
      end
    end else if (blink_cnt == BLINK_CYCLES - 1) begin
      blink_cnt <= '0;
      blink_vis <= ~blink_vis;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  logic blank_on;

  always_comb begin
    blank_on     = (state == HOLD) && !blink_vis;
    p1_games_seg = (blank_on && !winner) ? BLANK : p1_dig;
    p2_games_seg = (blank_on &&  winner) ? BLANK : p2_dig;
  end
`else
  always_comb begin
    p1_games_seg = p1_dig;
    p2_games_seg = p2_dig;
  end
`endif

endmodule
